icache_linefill_ctrl: RTL and testbench
=======================================

ICACHE_LINEFILL_CTRL -- requirements
Module: icache_linefill_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default MSHR_ENTRY_NUM (8): outstanding linefill slots, one per MSHR entry.
REQ-002 SHALL have parameter BEAT_NUM, default LINEFILL_BEAT_NUM (2): downstream data beats per 512b line.
REQ-003 SHALL have ports clk in 1 (clock) and rst_n in 1 (reset); one clock, reset asynchronous active-low.
REQ-004 SHALL have ports txreq_vld in 1, txreq_rdy out 1: miss request handshake from MSHR file.
REQ-005 SHALL have ports txreq_opcode in ICACHE_REQ_OPCODE_WIDTH, txreq_txnid in ICACHE_REQ_TXNID_WIDTH, txreq_addr in req_addr_t, txreq_index in MSHR_ENTRY_INDEX_WIDTH (slot id), txreq_way in 1 (victim way).
REQ-006 SHALL have ports bus_req_vld out 1, bus_req_rdy in 1, bus_req_opcode out, bus_req_txnid out MSHR_ENTRY_INDEX_WIDTH, bus_req_addr out req_addr_t: downstream read request.
REQ-007 SHALL have ports bus_rsp_vld in 1, bus_rsp_rdy out 1, bus_rsp_txnid in MSHR_ENTRY_INDEX_WIDTH, bus_rsp_data in DOWNSTREAM_DATA_WIDTH (256): read data beats.
REQ-008 SHALL have ports dataram_wr_vld out 1, dataram_wr_rdy in 1, dataram_wr_way out 1, dataram_wr_index out ICACHE_INDEX_WIDTH, dataram_wr_data out ICACHE_LINE_WIDTH (512).
REQ-009 SHALL have ports linefill_done out 1, linefill_ack_index out MSHR_ENTRY_INDEX_WIDTH, protocol_err out 1 (sticky).

Function
REQ-010 Each slot SHALL hold a state machine IDLE -> ISSUE -> WAIT_DATA -> WRITE -> IDLE.
REQ-011 txreq_rdy SHALL equal (state[txreq_index]==IDLE); on txreq handshake the slot captures addr, opcode, way and moves to ISSUE.
REQ-012 bus_req SHALL present the lowest-numbered ISSUE slot; bus_req_txnid = slot index; bus_req_addr = captured addr with 6 offset bits zeroed.
REQ-013 bus_req_vld/payload SHALL stay stable until bus_req_rdy; on handshake slot moves to WAIT_DATA, beat counter cleared.
REQ-014 bus_rsp_rdy SHALL be constant 1; each beat writes bus_rsp_data into slot[bus_rsp_txnid] line buffer at beat position beat_cnt (beat 0 = bits 255:0).
REQ-015 Beats of different txnids MAY interleave; per-slot counters SHALL be independent.
REQ-016 On the BEAT_NUM-th beat the slot SHALL move to WRITE on the next edge; beat counter wraps to 0.
REQ-017 A beat for a slot not in WAIT_DATA SHALL be dropped and SHALL set protocol_err until reset.
REQ-018 dataram_wr SHALL present the lowest-numbered WRITE slot: way = captured way, index = captured addr index field, data = assembled line; stable until dataram_wr_rdy.
REQ-019 On dataram_wr handshake the slot SHALL return to IDLE, and linefill_done SHALL pulse high for exactly one cycle on the following cycle with linefill_ack_index = that slot.
REQ-020 linefill_ack_index SHALL be 0 when linefill_done is 0.
REQ-021 A slot freed by REQ-019 SHALL be accepted by txreq in the same cycle linefill_done is high.
REQ-022 Simultaneous txreq accept, bus_req issue, rsp beat and dataram write on different slots SHALL all take effect in one cycle.
REQ-023 Latency: txreq accept to bus_req_vld = 1 cycle; last beat to dataram_wr_vld = 1 cycle; all with ready held high.

Reset
REQ-024 On rst_n low all slots SHALL go IDLE, beat counters 0, protocol_err 0, linefill_done 0; all *_vld outputs 0, txreq_rdy 1 after reset release; line buffers need not clear.
REQ-025 Reset mid-transfer SHALL abandon in-flight slots without asserting linefill_done.

Structure
REQ-026 ICACHE_LINE_WIDTH, DOWNSTREAM_DATA_WIDTH, LINEFILL_BEAT_NUM and the slot-state enum SHALL live in toy_pack.
REQ-027 Lowest-index selection for ISSUE and WRITE SHALL reuse cmn_lead_one; no other sub-module.

Verification
REQ-028 Single fill: txreq index 3 addr 0x0_1234_5678, way 1, beats A,B -> bus_req addr 0x0_1234_5640 txnid 3; dataram_wr index 0x59 way 1 data {B,A}; linefill_done with ack 3 one cycle later.
REQ-029 Interleave: slots 0 and 5 issued, beats 5a,0a,5b,0b -> slot 5 written first, then 0, each line correct.
REQ-030 Backpressure: bus_req_rdy low 4 cycles, dataram_wr_rdy low 3 cycles -> payloads stable, no duplicate done.
REQ-031 Collision: txreq to busy slot 2 -> txreq_rdy 0 until cycle of done for 2, accepted that cycle.
REQ-032 Stray beat txnid 6 with slot 6 IDLE -> dropped, protocol_err 1 until rst_n; reset during WAIT_DATA -> no linefill_done, all slots IDLE.

Source files
------------

// File: rtl/toy_pack.sv
// Shared widths, types and slot-state encoding for the icache linefill path.
`default_nettype none

package toy_pack;

    localparam int MSHR_ENTRY_NUM          = 8;
    localparam int MSHR_ENTRY_INDEX_WIDTH  = $clog2(MSHR_ENTRY_NUM);
    localparam int LINEFILL_BEAT_NUM       = 2;
    localparam int ICACHE_LINE_WIDTH       = 512;
    localparam int DOWNSTREAM_DATA_WIDTH   = 256;
    localparam int ICACHE_REQ_OPCODE_WIDTH = 3;
    localparam int ICACHE_REQ_TXNID_WIDTH  = 4;
    localparam int PADDR_WIDTH             = 36;
    localparam int ICACHE_OFFSET_WIDTH     = 6;
    localparam int ICACHE_INDEX_WIDTH      = 7;

    typedef logic [PADDR_WIDTH-1:0] req_addr_t;

    typedef enum logic [1:0] {
        SLOT_IDLE      = 2'd0,
        SLOT_ISSUE     = 2'd1,
        SLOT_WAIT_DATA = 2'd2,
        SLOT_WRITE     = 2'd3
    } linefill_state_e;

endpackage

`default_nettype wire

// File: rtl/cmn_lead_one.sv
// Lowest-set-bit finder: returns index of the least significant 1 in in_vec.
`default_nettype none

module cmn_lead_one #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic             lead_one_vld,
    output logic [IDX_W-1:0] lead_one_idx
);

    always_comb begin
        lead_one_vld = |in_vec;
        lead_one_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                lead_one_idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/icache_linefill_ctrl.sv
// Per-MSHR-slot linefill engine: issues downstream reads, assembles beats into
// a line buffer, and writes the finished line into the data RAM.
`default_nettype none

module icache_linefill_ctrl
    import toy_pack::*;
#(
    parameter int ENTRY_NUM = MSHR_ENTRY_NUM,
    parameter int BEAT_NUM  = LINEFILL_BEAT_NUM
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               txreq_vld,
    output logic                               txreq_rdy,
    input  logic [ICACHE_REQ_OPCODE_WIDTH-1:0] txreq_opcode,
    input  logic [ICACHE_REQ_TXNID_WIDTH-1:0]  txreq_txnid,
    input  req_addr_t                          txreq_addr,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  txreq_index,
    input  logic                               txreq_way,

    output logic                               bus_req_vld,
    input  logic                               bus_req_rdy,
    output logic [ICACHE_REQ_OPCODE_WIDTH-1:0] bus_req_opcode,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  bus_req_txnid,
    output req_addr_t                          bus_req_addr,

    input  logic                               bus_rsp_vld,
    output logic                               bus_rsp_rdy,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  bus_rsp_txnid,
    input  logic [DOWNSTREAM_DATA_WIDTH-1:0]   bus_rsp_data,

    output logic                               dataram_wr_vld,
    input  logic                               dataram_wr_rdy,
    output logic                               dataram_wr_way,
    output logic [ICACHE_INDEX_WIDTH-1:0]      dataram_wr_index,
    output logic [ICACHE_LINE_WIDTH-1:0]       dataram_wr_data,

    output logic                               linefill_done,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  linefill_ack_index,
    output logic                               protocol_err
);

    localparam int IDX_W = MSHR_ENTRY_INDEX_WIDTH;
    localparam int CNT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
    localparam int DW    = DOWNSTREAM_DATA_WIDTH;
    localparam int OFF_W = ICACHE_OFFSET_WIDTH;

    linefill_state_e                    state_q    [ENTRY_NUM];
    linefill_state_e                    state_d    [ENTRY_NUM];
    logic [CNT_W-1:0]                   beat_cnt_q [ENTRY_NUM];
    logic [CNT_W-1:0]                   beat_cnt_d [ENTRY_NUM];
    req_addr_t                          addr_q     [ENTRY_NUM];
    req_addr_t                          addr_d     [ENTRY_NUM];
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0] opcode_q   [ENTRY_NUM];
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0] opcode_d   [ENTRY_NUM];
    logic                               way_q      [ENTRY_NUM];
    logic                               way_d      [ENTRY_NUM];
    logic [ICACHE_LINE_WIDTH-1:0]       line_q     [ENTRY_NUM];
    logic [ICACHE_LINE_WIDTH-1:0]       line_d     [ENTRY_NUM];

    logic             issue_lock_q, issue_lock_d;
    logic [IDX_W-1:0] issue_sel_q,  issue_sel_d;
    logic             write_lock_q, write_lock_d;
    logic [IDX_W-1:0] write_sel_q,  write_sel_d;
    logic             done_q,       done_d;
    logic [IDX_W-1:0] ack_idx_q,    ack_idx_d;
    logic             perr_q,       perr_d;

    logic [ENTRY_NUM-1:0] issue_vec;
    logic [ENTRY_NUM-1:0] write_vec;
    logic                 issue_lead_vld;
    logic [IDX_W-1:0]     issue_lead_idx;
    logic                 write_lead_vld;
    logic [IDX_W-1:0]     write_lead_idx;
    logic [IDX_W-1:0]     issue_idx;
    logic [IDX_W-1:0]     write_idx;
    logic                 txreq_fire;
    logic                 issue_fire;
    logic                 write_fire;
    logic                 rsp_ok;
    logic                 unused_inputs;

    assign unused_inputs = ^{txreq_txnid, txreq_addr[OFF_W-1:0]};

    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            issue_vec[i] = (state_q[i] == SLOT_ISSUE);
            write_vec[i] = (state_q[i] == SLOT_WRITE);
        end
    end

    cmn_lead_one #(.WIDTH(ENTRY_NUM), .IDX_W(IDX_W)) u_issue_pick (
        .in_vec       (issue_vec),
        .lead_one_vld (issue_lead_vld),
        .lead_one_idx (issue_lead_idx)
    );

    cmn_lead_one #(.WIDTH(ENTRY_NUM), .IDX_W(IDX_W)) u_write_pick (
        .in_vec       (write_vec),
        .lead_one_vld (write_lead_vld),
        .lead_one_idx (write_lead_idx)
    );

    // A stalled offer is pinned so a lower slot arriving later cannot swap the payload.
    assign issue_idx      = issue_lock_q ? issue_sel_q : issue_lead_idx;
    assign bus_req_vld    = issue_lock_q | issue_lead_vld;
    assign write_idx      = write_lock_q ? write_sel_q : write_lead_idx;
    assign dataram_wr_vld = write_lock_q | write_lead_vld;

    assign bus_req_txnid      = issue_idx;
    assign bus_rsp_rdy        = 1'b1;
    assign linefill_done      = done_q;
    assign linefill_ack_index = ack_idx_q;
    assign protocol_err       = perr_q;

    assign txreq_fire = txreq_vld & txreq_rdy;
    assign issue_fire = bus_req_vld & bus_req_rdy;
    assign write_fire = dataram_wr_vld & dataram_wr_rdy;

    always_comb begin
        txreq_rdy        = 1'b0;
        bus_req_opcode   = '0;
        bus_req_addr     = '0;
        dataram_wr_way   = 1'b0;
        dataram_wr_index = '0;
        dataram_wr_data  = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (txreq_index == IDX_W'(i)) begin
                txreq_rdy = (state_q[i] == SLOT_IDLE);
            end
            if (issue_idx == IDX_W'(i)) begin
                bus_req_opcode = opcode_q[i];
                bus_req_addr   = addr_q[i];
            end
            if (write_idx == IDX_W'(i)) begin
                dataram_wr_way   = way_q[i];
                dataram_wr_index = addr_q[i][OFF_W +: ICACHE_INDEX_WIDTH];
                dataram_wr_data  = line_q[i];
            end
        end
    end

    always_comb begin
        issue_lock_d = bus_req_vld & ~bus_req_rdy;
        issue_sel_d  = issue_idx;
        write_lock_d = dataram_wr_vld & ~dataram_wr_rdy;
        write_sel_d  = write_idx;
        done_d       = write_fire;
        ack_idx_d    = write_fire ? write_idx : '0;
        rsp_ok       = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            state_d[i]    = state_q[i];
            beat_cnt_d[i] = beat_cnt_q[i];
            addr_d[i]     = addr_q[i];
            opcode_d[i]   = opcode_q[i];
            way_d[i]      = way_q[i];
            line_d[i]     = line_q[i];
            if (txreq_fire && txreq_index == IDX_W'(i)) begin
                state_d[i]  = SLOT_ISSUE;
                addr_d[i]   = {txreq_addr[PADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                opcode_d[i] = txreq_opcode;
                way_d[i]    = txreq_way;
            end
            if (issue_fire && issue_idx == IDX_W'(i)) begin
                state_d[i]    = SLOT_WAIT_DATA;
                beat_cnt_d[i] = '0;
            end
            if (bus_rsp_vld && bus_rsp_txnid == IDX_W'(i) && state_q[i] == SLOT_WAIT_DATA) begin
                rsp_ok = 1'b1;
                for (int b = 0; b < BEAT_NUM; b++) begin
                    if (beat_cnt_q[i] == CNT_W'(b)) begin
                        line_d[i][b*DW +: DW] = bus_rsp_data;
                    end
                end
                if (beat_cnt_q[i] == CNT_W'(BEAT_NUM - 1)) begin
                    beat_cnt_d[i] = '0;
                    state_d[i]    = SLOT_WRITE;
                end else begin
                    beat_cnt_d[i] = beat_cnt_q[i] + CNT_W'(1);
                end
            end
            if (write_fire && write_idx == IDX_W'(i)) begin
                state_d[i] = SLOT_IDLE;
            end
        end
        perr_d = perr_q | (bus_rsp_vld & ~rsp_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i]    <= SLOT_IDLE;
                beat_cnt_q[i] <= '0;
                addr_q[i]     <= '0;
                opcode_q[i]   <= '0;
                way_q[i]      <= 1'b0;
            end
            issue_lock_q <= 1'b0;
            issue_sel_q  <= '0;
            write_lock_q <= 1'b0;
            write_sel_q  <= '0;
            done_q       <= 1'b0;
            ack_idx_q    <= '0;
            perr_q       <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i]    <= state_d[i];
                beat_cnt_q[i] <= beat_cnt_d[i];
                addr_q[i]     <= addr_d[i];
                opcode_q[i]   <= opcode_d[i];
                way_q[i]      <= way_d[i];
            end
            issue_lock_q <= issue_lock_d;
            issue_sel_q  <= issue_sel_d;
            write_lock_q <= write_lock_d;
            write_sel_q  <= write_sel_d;
            done_q       <= done_d;
            ack_idx_q    <= ack_idx_d;
            perr_q       <= perr_d;
        end
    end

    // Line buffers carry no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            line_q[i] <= line_d[i];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_linefill_ctrl.sv
// Directed self-checking bench for icache_linefill_ctrl.
`default_nettype none

module tb_icache_linefill_ctrl;
    import toy_pack::*;

    logic                               clk;
    logic                               rst_n;
    logic                               txreq_vld;
    logic                               txreq_rdy;
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0] txreq_opcode;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]  txreq_txnid;
    req_addr_t                          txreq_addr;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  txreq_index;
    logic                               txreq_way;
    logic                               bus_req_vld;
    logic                               bus_req_rdy;
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0] bus_req_opcode;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  bus_req_txnid;
    req_addr_t                          bus_req_addr;
    logic                               bus_rsp_vld;
    logic                               bus_rsp_rdy;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  bus_rsp_txnid;
    logic [DOWNSTREAM_DATA_WIDTH-1:0]   bus_rsp_data;
    logic                               dataram_wr_vld;
    logic                               dataram_wr_rdy;
    logic                               dataram_wr_way;
    logic [ICACHE_INDEX_WIDTH-1:0]      dataram_wr_index;
    logic [ICACHE_LINE_WIDTH-1:0]       dataram_wr_data;
    logic                               linefill_done;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  linefill_ack_index;
    logic                               protocol_err;

    int errors = 0;
    int checks = 0;

    logic [255:0] d_a, d_b, d5a, d5b, d0a, d0b, e1a, e1b, e0a, e0b, f2a, f2b;

    icache_linefill_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .txreq_vld          (txreq_vld),
        .txreq_rdy          (txreq_rdy),
        .txreq_opcode       (txreq_opcode),
        .txreq_txnid        (txreq_txnid),
        .txreq_addr         (txreq_addr),
        .txreq_index        (txreq_index),
        .txreq_way          (txreq_way),
        .bus_req_vld        (bus_req_vld),
        .bus_req_rdy        (bus_req_rdy),
        .bus_req_opcode     (bus_req_opcode),
        .bus_req_txnid      (bus_req_txnid),
        .bus_req_addr       (bus_req_addr),
        .bus_rsp_vld        (bus_rsp_vld),
        .bus_rsp_rdy        (bus_rsp_rdy),
        .bus_rsp_txnid      (bus_rsp_txnid),
        .bus_rsp_data       (bus_rsp_data),
        .dataram_wr_vld     (dataram_wr_vld),
        .dataram_wr_rdy     (dataram_wr_rdy),
        .dataram_wr_way     (dataram_wr_way),
        .dataram_wr_index   (dataram_wr_index),
        .dataram_wr_data    (dataram_wr_data),
        .linefill_done      (linefill_done),
        .linefill_ack_index (linefill_ack_index),
        .protocol_err       (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; txreq_vld = 1'b0; txreq_opcode = '0; txreq_txnid = '0;
        txreq_addr = '0; txreq_index = '0; txreq_way = 1'b0;
        bus_req_rdy = 1'b1; bus_rsp_vld = 1'b0; bus_rsp_txnid = '0; bus_rsp_data = '0;
        dataram_wr_rdy = 1'b1;
        d_a = {8{32'hA0A0_0001}}; d_b = {8{32'hB0B0_0002}};
        d5a = {8{32'h5A5A_0003}}; d5b = {8{32'h5B5B_0004}};
        d0a = {8{32'h0A0A_0005}}; d0b = {8{32'h0B0B_0006}};
        e1a = {8{32'hE1A0_0007}}; e1b = {8{32'hE1B0_0008}};
        e0a = {8{32'hE0A0_0009}}; e0b = {8{32'hE0B0_000A}};
        f2a = {8{32'hF2A0_000B}}; f2b = {8{32'hF2B0_000C}};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_vld",  bus_req_vld,    0);
        chk("rst_wr_vld",   dataram_wr_vld, 0);
        chk("rst_done",     linefill_done,  0);
        chk("rst_perr",     protocol_err,   0);
        chk("rst_rsp_rdy",  bus_rsp_rdy,    1);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_txreq_rdy", txreq_rdy, 1);

        // Single fill, slot 3
        @(negedge clk);
        txreq_vld = 1; txreq_index = 3; txreq_addr = 36'h0_1234_5678; txreq_way = 1; txreq_opcode = 3'h5; #1;
        chk("t1_txreq_rdy", txreq_rdy, 1);
        chk("t1_bus_vld_pre", bus_req_vld, 0);
        @(negedge clk); txreq_vld = 0; #1;
        chk("t1_bus_vld",   bus_req_vld,    1);
        chk("t1_bus_txnid", bus_req_txnid,  3);
        chk("t1_bus_addr",  bus_req_addr,   36'h0_1234_5640);
        chk("t1_bus_opc",   bus_req_opcode, 3'h5);
        @(negedge clk); bus_rsp_vld = 1; bus_rsp_txnid = 3; bus_rsp_data = d_a; #1;
        chk("t1_bus_vld_post", bus_req_vld, 0);
        @(negedge clk); bus_rsp_data = d_b; #1;
        chk("t1_wr_vld_early", dataram_wr_vld, 0);
        @(negedge clk); bus_rsp_vld = 0; #1;
        chk("t1_wr_vld",   dataram_wr_vld,   1);
        chk("t1_wr_index", dataram_wr_index, 7'h59);
        chk("t1_wr_way",   dataram_wr_way,   1);
        chk("t1_wr_data",  dataram_wr_data,  {d_b, d_a});
        chk("t1_done_early", linefill_done,  0);
        @(negedge clk); #1;
        chk("t1_done",   linefill_done,      1);
        chk("t1_ack",    linefill_ack_index, 3);
        chk("t1_wr_vld_post", dataram_wr_vld, 0);
        @(negedge clk); #1;
        chk("t1_done_off", linefill_done,      0);
        chk("t1_ack_off",  linefill_ack_index, 0);

        // Interleaved beats, slots 0 and 5
        @(negedge clk);
        txreq_vld = 1; txreq_index = 0; txreq_addr = 36'h0_0000_1040; txreq_way = 0; txreq_opcode = 3'h1; #1;
        chk("t2_rdy0", txreq_rdy, 1);
        @(negedge clk);
        txreq_index = 5; txreq_addr = 36'h0_ABCD_E0FF; txreq_way = 1; txreq_opcode = 3'h2; #1;
        chk("t2_rdy5",     txreq_rdy,     1);
        chk("t2_txnid0",   bus_req_txnid, 0);
        chk("t2_addr0",    bus_req_addr,  36'h0_0000_1040);
        @(negedge clk); txreq_vld = 0; #1;
        chk("t2_vld5",     bus_req_vld,    1);
        chk("t2_txnid5",   bus_req_txnid,  5);
        chk("t2_addr5",    bus_req_addr,   36'h0_ABCD_E0C0);
        chk("t2_opc5",     bus_req_opcode, 3'h2);
        @(negedge clk); bus_rsp_vld = 1; bus_rsp_txnid = 5; bus_rsp_data = d5a; #1;
        chk("t2_bus_idle", bus_req_vld, 0);
        @(negedge clk); bus_rsp_txnid = 0; bus_rsp_data = d0a;
        @(negedge clk); bus_rsp_txnid = 5; bus_rsp_data = d5b;
        @(negedge clk); bus_rsp_txnid = 0; bus_rsp_data = d0b; #1;
        chk("t2_wr5_vld",  dataram_wr_vld,   1);
        chk("t2_wr5_idx",  dataram_wr_index, 7'h03);
        chk("t2_wr5_way",  dataram_wr_way,   1);
        chk("t2_wr5_data", dataram_wr_data,  {d5b, d5a});
        @(negedge clk); bus_rsp_vld = 0; #1;
        chk("t2_done5",    linefill_done,      1);
        chk("t2_ack5",     linefill_ack_index, 5);
        chk("t2_wr0_vld",  dataram_wr_vld,     1);
        chk("t2_wr0_idx",  dataram_wr_index,   7'h41);
        chk("t2_wr0_way",  dataram_wr_way,     0);
        chk("t2_wr0_data", dataram_wr_data,    {d0b, d0a});
        @(negedge clk); #1;
        chk("t2_done0",    linefill_done,      1);
        chk("t2_ack0",     linefill_ack_index, 0);
        chk("t2_wr_idle",  dataram_wr_vld,     0);
        @(negedge clk); #1;
        chk("t2_done_off", linefill_done, 0);
        chk("t2_perr",     protocol_err,  0);

        // Backpressure: bus_req_rdy low 4 cycles, dataram_wr_rdy low 3 cycles
        bus_req_rdy = 0;
        @(negedge clk);
        txreq_vld = 1; txreq_index = 1; txreq_addr = 36'h0_0000_2080; txreq_way = 0; txreq_opcode = 3'h3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                txreq_vld = 1; txreq_index = 0; txreq_addr = 36'h0_0000_30C0; txreq_way = 1; txreq_opcode = 3'h4;
            end else begin
                txreq_vld = 0;
            end
            #1;
            chk("t3_bus_vld_hold",   bus_req_vld,    1);
            chk("t3_bus_txnid_hold", bus_req_txnid,  1);
            chk("t3_bus_addr_hold",  bus_req_addr,   36'h0_0000_2080);
            chk("t3_bus_opc_hold",   bus_req_opcode, 3'h3);
        end
        @(negedge clk); bus_req_rdy = 1; #1;
        chk("t3_bus_txnid1", bus_req_txnid, 1);
        @(negedge clk); bus_rsp_vld = 1; bus_rsp_txnid = 1; bus_rsp_data = e1a; #1;
        chk("t3_bus_txnid0", bus_req_txnid, 0);
        chk("t3_bus_addr0",  bus_req_addr,  36'h0_0000_30C0);
        @(negedge clk); bus_rsp_data = e1b;
        @(negedge clk); dataram_wr_rdy = 0; bus_rsp_txnid = 0; bus_rsp_data = e0a; #1;
        chk("t3_wr_idx_c0", dataram_wr_index, 7'h02);
        chk("t3_wr_dat_c0", dataram_wr_data,  {e1b, e1a});
        @(negedge clk); bus_rsp_data = e0b; #1;
        chk("t3_wr_idx_c1", dataram_wr_index, 7'h02);
        chk("t3_done_c1",   linefill_done,    0);
        @(negedge clk); bus_rsp_vld = 0; #1;
        chk("t3_wr_idx_c2", dataram_wr_index, 7'h02);
        chk("t3_wr_dat_c2", dataram_wr_data,  {e1b, e1a});
        chk("t3_wr_way_c2", dataram_wr_way,   0);
        chk("t3_done_c2",   linefill_done,    0);
        @(negedge clk); dataram_wr_rdy = 1; #1;
        chk("t3_wr_idx_rel", dataram_wr_index, 7'h02);
        chk("t3_done_rel",   linefill_done,    0);
        @(negedge clk); #1;
        chk("t3_done1",    linefill_done,      1);
        chk("t3_ack1",     linefill_ack_index, 1);
        chk("t3_wr0_idx",  dataram_wr_index,   7'h43);
        chk("t3_wr0_data", dataram_wr_data,    {e0b, e0a});
        chk("t3_wr0_way",  dataram_wr_way,     1);
        @(negedge clk); #1;
        chk("t3_done0",    linefill_done,      1);
        chk("t3_ack0",     linefill_ack_index, 0);
        chk("t3_wr_idle",  dataram_wr_vld,     0);
        @(negedge clk); #1;
        chk("t3_no_dup",   linefill_done, 0);

        // Collision on busy slot 2
        @(negedge clk);
        txreq_vld = 1; txreq_index = 2; txreq_addr = 36'h0_0000_4000; txreq_way = 0; txreq_opcode = 3'h1; #1;
        chk("t4_rdy_first", txreq_rdy, 1);
        @(negedge clk); txreq_addr = 36'h0_0000_5040; txreq_way = 1; txreq_opcode = 3'h6; #1;
        chk("t4_rdy_busy0", txreq_rdy,     0);
        chk("t4_txnid2",    bus_req_txnid, 2);
        @(negedge clk); bus_rsp_vld = 1; bus_rsp_txnid = 2; bus_rsp_data = f2a; #1;
        chk("t4_rdy_busy1", txreq_rdy, 0);
        @(negedge clk); bus_rsp_data = f2b; #1;
        chk("t4_rdy_busy2", txreq_rdy, 0);
        @(negedge clk); bus_rsp_vld = 0; dataram_wr_rdy = 0; #1;
        chk("t4_rdy_busy3", txreq_rdy,       0);
        chk("t4_wr_data",   dataram_wr_data, {f2b, f2a});
        chk("t4_wr_idx",    dataram_wr_index, 7'h00);
        @(negedge clk); dataram_wr_rdy = 1; #1;
        chk("t4_rdy_busy4", txreq_rdy,     0);
        chk("t4_done_pre",  linefill_done, 0);
        @(negedge clk); #1;
        chk("t4_done2",     linefill_done,      1);
        chk("t4_ack2",      linefill_ack_index, 2);
        chk("t4_rdy_free",  txreq_rdy,          1);
        @(negedge clk); txreq_vld = 0; #1;
        chk("t4_reissue_vld",  bus_req_vld,    1);
        chk("t4_reissue_txn",  bus_req_txnid,  2);
        chk("t4_reissue_addr", bus_req_addr,   36'h0_0000_5040);
        chk("t4_reissue_opc",  bus_req_opcode, 3'h6);

        // Stray beat, then reset with slot 2 in WAIT_DATA
        @(negedge clk); bus_rsp_vld = 1; bus_rsp_txnid = 6; bus_rsp_data = d_a; #1;
        chk("t5_perr_pre", protocol_err, 0);
        @(negedge clk); bus_rsp_txnid = 2; bus_rsp_data = d_b; #1;
        chk("t5_perr_set", protocol_err, 1);
        @(negedge clk); bus_rsp_vld = 0; #1;
        chk("t5_perr_sticky", protocol_err,   1);
        chk("t5_wr_idle",     dataram_wr_vld, 0);
        rst_n = 0; #1;
        chk("t5_rst_perr", protocol_err,  0);
        chk("t5_rst_done", linefill_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("t5_post_done",    linefill_done,  0);
            chk("t5_post_bus_vld", bus_req_vld,    0);
            chk("t5_post_wr_vld",  dataram_wr_vld, 0);
        end
        for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
            txreq_index = MSHR_ENTRY_INDEX_WIDTH'(i); #1;
            chk("t5_slot_idle", txreq_rdy, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
